// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: writes mode/M/N/C/start over the Avalon-MM management port,
// polls status, waits for relock, and resets the PLL on lock loss. Lock timeout: `PLL_RECONFIG_TIMEOUT_EN.
module pll_reconfig_seq #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [17:0] cfg_m,
    input  logic [17:0] cfg_n,
    input  logic [17:0] cfg_c,
    input  logic [4:0]  cfg_c_sel,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic        mgmt_read,
    output logic [31:0] mgmt_writedata,
    input  logic [31:0] mgmt_readdata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        pll_rst
);

    localparam logic [5:0] ADDR_MODE  = 6'h00;
    localparam logic [5:0] ADDR_STAT  = 6'h01;
    localparam logic [5:0] ADDR_START = 6'h02;
    localparam logic [5:0] ADDR_N     = 6'h03;
    localparam logic [5:0] ADDR_M     = 6'h04;
    localparam logic [5:0] ADDR_C     = 6'h05;

    localparam int CNT_MAX = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_MODE,
        S_WR_M,
        S_WR_N,
        S_WR_C,
        S_WR_START,
        S_RD_STAT,
        S_WAIT_LOCK,
        S_PLL_RST
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       sync_q;
    logic             lock_s;
    logic             lock_prev_q;
    logic             lock_fall;
    logic [17:0]      m_q, m_d;
    logic [17:0]      n_q, n_d;
    logic [17:0]      c_q, c_d;
    logic [4:0]       c_sel_q, c_sel_d;
    logic             from_req_q, from_req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             write_q, write_d;
    logic             read_q, read_d;
    logic             done_q, done_d;
    logic             pll_rst_q, pll_rst_d;
    logic             xfer_done;
    logic             unused_rdata;
`ifdef PLL_RECONFIG_TIMEOUT_EN
    logic             err_q, err_d;
`endif

    // pll_locked is asynchronous to clk; only the second flop is ever used.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q      <= 2'b00;
            lock_prev_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            sync_q      <= {sync_q[0], pll_locked};
            lock_prev_q <= lock_s;
        end
    end

    assign lock_s       = sync_q[1];
    assign lock_fall    = lock_prev_q & ~lock_s;
    assign xfer_done    = (write_q | read_q) & ~mgmt_waitrequest;
    assign unused_rdata = ^mgmt_readdata[31:1];

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        state_d    = state_q;
        m_d        = m_q;
        n_d        = n_q;
        c_d        = c_q;
        c_sel_d    = c_sel_q;
        from_req_d = from_req_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        read_d     = read_q;
        done_d     = 1'b0;
`ifdef PLL_RECONFIG_TIMEOUT_EN
        err_d      = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    m_d        = cfg_m;
                    n_d        = cfg_n;
                    c_d        = cfg_c;
                    c_sel_d    = cfg_c_sel;
                    from_req_d = 1'b1;
                    state_d    = S_WR_MODE;
                end else if (lock_fall) begin
                    from_req_d = 1'b0;
                    state_d    = S_PLL_RST;
                end
            end
            S_WR_MODE:  if (xfer_done) state_d = S_WR_M;
            S_WR_M:     if (xfer_done) state_d = S_WR_N;
            S_WR_N:     if (xfer_done) state_d = S_WR_C;
            S_WR_C:     if (xfer_done) state_d = S_WR_START;
            S_WR_START: if (xfer_done) state_d = S_RD_STAT;
            S_RD_STAT: begin
                if (xfer_done && mgmt_readdata[0]) begin
                    state_d = S_WAIT_LOCK;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s) begin
                    done_d  = from_req_q;
                    state_d = S_IDLE;
                end
`ifdef PLL_RECONFIG_TIMEOUT_EN
                else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_PLL_RST;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_PLL_RST: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = S_WAIT_LOCK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // Bus registers are loaded for the state being entered, so a completing transfer is
        // followed back-to-back by the next one; a failed status read is simply reissued.
        if ((state_d != state_q) || (state_q == S_RD_STAT && xfer_done)) begin
            write_d = 1'b0;
            read_d  = 1'b0;
            case (state_d)
                S_WR_MODE: begin
                    write_d = 1'b1;
                    addr_d  = ADDR_MODE;
                    wdata_d = 32'h1;
                end
                S_WR_M: begin
                    write_d = 1'b1;
                    addr_d  = ADDR_M;
                    wdata_d = {14'b0, m_q};
                end
                S_WR_N: begin
                    write_d = 1'b1;
                    addr_d  = ADDR_N;
                    wdata_d = {14'b0, n_q};
                end
                S_WR_C: begin
                    write_d = 1'b1;
                    addr_d  = ADDR_C;
                    wdata_d = {9'b0, c_sel_q, c_q};
                end
                S_WR_START: begin
                    write_d = 1'b1;
                    addr_d  = ADDR_START;
                    wdata_d = 32'h1;
                end
                S_RD_STAT: begin
                    read_d  = 1'b1;
                    addr_d  = ADDR_STAT;
                    wdata_d = 32'h0;
                end
                default: ;
            endcase
        end

        pll_rst_d = (state_d == S_PLL_RST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            // NOTE: the holding registers are a handful of flops, not a RAM, so they take the reset too.
            m_q        <= '0;
            n_q        <= '0;
            c_q        <= '0;
            c_sel_q    <= '0;
            from_req_q <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            read_q     <= 1'b0;
            done_q     <= 1'b0;
            pll_rst_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_q        <= m_d;
            n_q        <= n_d;
            c_q        <= c_d;
            c_sel_q    <= c_sel_d;
            from_req_q <= from_req_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            read_q     <= read_d;
            done_q     <= done_d;
            pll_rst_q  <= pll_rst_d;
        end
    end

`ifdef PLL_RECONFIG_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign mgmt_address   = addr_q;
    assign mgmt_write     = write_q;
    assign mgmt_read      = read_q;
    assign mgmt_writedata = wdata_q;
    assign pll_rst        = pll_rst_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Self-checking bench for pll_reconfig_seq: random configs, random wait-states and status
// answers from an Avalon slave model, expected transfers and timing derived from the behaviour rules.
module tb_pll_reconfig_seq;

    localparam int RST_CYCLES = 16;
`ifdef PLL_RECONFIG_TIMEOUT_EN
    localparam int LOCK_TIMEOUT = 100;
`else
    localparam int LOCK_TIMEOUT = 65535;
`endif

    typedef struct packed {
        logic        rd;
        logic [5:0]  addr;
        logic [31:0] data;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [17:0] cfg_m = '0;
    logic [17:0] cfg_n = '0;
    logic [17:0] cfg_c = '0;
    logic [4:0]  cfg_c_sel = '0;
    logic        busy, done, err;
    logic [5:0]  mgmt_address;
    logic        mgmt_write, mgmt_read;
    logic [31:0] mgmt_writedata;
    logic [31:0] mgmt_readdata = '0;
    logic        mgmt_waitrequest = 1'b0;
    logic        pll_locked = 1'b1;
    logic        pll_rst;

    int    total = 0;
    int    bad = 0;
    int    stall_min = 0;
    int    stall_max = 0;
    int    stall_left = -1;
    int    zeros_left = 0;
    bit    stat_ok = 1'b0;
    int    done_cnt = 0;
    int    err_cnt = 0;
    int    err_exp = 0;
    xfer_t obs_q[$];
    xfer_t held;
    xfer_t cur;

    pll_reconfig_seq #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req              (req),
        .cfg_m            (cfg_m),
        .cfg_n            (cfg_n),
        .cfg_c            (cfg_c),
        .cfg_c_sel        (cfg_c_sel),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_read        (mgmt_read),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_readdata    (mgmt_readdata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .pll_locked       (pll_locked),
        .pll_rst          (pll_rst)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic xfer_t mk(input logic rd, input logic [5:0] addr, input logic [31:0] data);
        xfer_t x;
        x.rd   = rd;
        x.addr = addr;
        x.data = data;
        return x;
    endfunction

    // Avalon slave model: random wait-states, status answers, transfer log, pulse counters.
    always @(negedge clk) begin
        if (!rst_n) begin
            mgmt_waitrequest = 1'b0;
            stall_left       = -1;
        end else begin
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (mgmt_write || mgmt_read) begin
                cur = mk(mgmt_read, mgmt_address, mgmt_read ? 32'h0 : mgmt_writedata);
                if (stall_left < 0) begin
                    held       = cur;
                    stall_left = int'($urandom_range(stall_max, stall_min));
                end else begin
                    check("stall_stable", 64'(cur), 64'(held));
                end
                if (stall_left > 0) begin
                    mgmt_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    mgmt_waitrequest = 1'b0;
                    stall_left       = -1;
                    obs_q.push_back(cur);
                    if (cur.rd) begin
                        mgmt_readdata = $urandom;
                        if (zeros_left > 0) begin
                            mgmt_readdata[0] = 1'b0;
                            zeros_left--;
                        end else begin
                            mgmt_readdata[0] = 1'b1;
                            stat_ok          = 1'b1;
                        end
                    end
                end
            end else begin
                mgmt_waitrequest = 1'b0;
                stall_left       = -1;
            end
        end
    end

    task automatic run_seq(input string name, input logic [17:0] m, input logic [17:0] n,
                           input logic [4:0] cs, input logic [17:0] c,
                           input int smin, input int smax, input int zeros, input bit inject);
        xfer_t exp_q[$];
        int    cyc;
        int    lat;
        int    d0;
        bit    injected;
        exp_q.push_back(mk(1'b0, 6'h00, 32'h1));
        exp_q.push_back(mk(1'b0, 6'h04, {14'b0, m}));
        exp_q.push_back(mk(1'b0, 6'h03, {14'b0, n}));
        exp_q.push_back(mk(1'b0, 6'h05, {9'b0, cs, c}));
        exp_q.push_back(mk(1'b0, 6'h02, 32'h1));
        for (int i = 0; i <= zeros; i++) exp_q.push_back(mk(1'b1, 6'h01, 32'h0));
        obs_q.delete();
        stat_ok    = 1'b0;
        zeros_left = zeros;
        stall_min  = smin;
        stall_max  = smax;
        d0         = done_cnt;
        injected   = 1'b0;

        @(negedge clk);
        req        = 1'b1;
        cfg_m      = m;
        cfg_n      = n;
        cfg_c      = c;
        cfg_c_sel  = cs;
        pll_locked = 1'b0;
        @(negedge clk);
        req       = 1'b0;
        cfg_m     = ~m;
        cfg_n     = ~n;
        cfg_c     = ~c;
        cfg_c_sel = ~cs;
        check({name, ":first_write"}, 64'({mgmt_write, mgmt_read, mgmt_address}), 64'({1'b1, 1'b0, 6'h00}));
        check({name, ":busy"}, 64'(busy), 64'(1));

        cyc = 0;
        while (!stat_ok && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (inject && !injected && mgmt_write && mgmt_address == 6'h03) begin
                injected  = 1'b1;
                req       = 1'b1;
                cfg_m     = 18'($urandom);
                cfg_c_sel = 5'($urandom);
                @(negedge clk);
                req = 1'b0;
                cyc++;
            end
        end
        check({name, ":status_ok"}, 64'(stat_ok), 64'(1));

        repeat ($urandom_range(12, 1)) @(negedge clk);
        pll_locked = 1'b1;
        lat = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, ":lock_to_done"}, 64'(lat), 64'(3));
        check({name, ":idle_at_done"}, 64'(busy), 64'(0));
        @(negedge clk);
        check({name, ":done_one_cycle"}, 64'(done), 64'(0));
        check({name, ":done_count"}, 64'(done_cnt - d0), 64'(1));
        check({name, ":xfer_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check($sformatf("%s:xfer%0d", name, i), 64'(obs_q[i]), 64'(exp_q[i]));
        end
    endtask

    initial begin
        int lat;
        int width;
        int d0;

        #1;
        check("reset_outputs", 64'({busy, done, err, mgmt_write, mgmt_read, pll_rst, mgmt_address, mgmt_writedata}), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_after_reset", 64'(busy), 64'(0));

        run_seq("nominal", 18'h00404, 18'h10000, 5'd0, 18'h00303, 0, 0, 0, 1'b0);
        run_seq("stretch", 18'($urandom), 18'($urandom), 5'($urandom), 18'($urandom), 3, 3, 0, 1'b0);
        run_seq("stat_poll", 18'($urandom), 18'($urandom), 5'($urandom), 18'($urandom), 0, 0, 3, 1'b0);
        run_seq("req_in_wr_n", 18'($urandom), 18'($urandom), 5'($urandom), 18'($urandom), 1, 2, 0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            run_seq($sformatf("rand%0d", k), 18'($urandom), 18'($urandom), 5'($urandom), 18'($urandom),
                    0, int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), 1'($urandom));
        end

        // Lock loss while idle: reset pulse, wait for relock, no done.
        repeat (4) @(negedge clk);
        d0 = done_cnt;
        pll_locked = 1'b0;
        lat = 0;
        while (!pll_rst && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("lockloss_to_rst", 64'(lat), 64'(3));
        check("lockloss_busy", 64'(busy), 64'(1));
        width = 0;
        while (pll_rst && width < 100) begin
            @(negedge clk);
            width++;
        end
        check("rst_width", 64'(width), 64'(RST_CYCLES));
`ifdef PLL_RECONFIG_TIMEOUT_EN
        lat = 0;
        while (!err && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        check("timeout_cycles", 64'(lat), 64'(LOCK_TIMEOUT));
        check("timeout_rst", 64'(pll_rst), 64'(1));
        err_exp++;
        width = 0;
        while (pll_rst && width < 100) begin
            @(negedge clk);
            width++;
        end
        check("retry_rst_width", 64'(width), 64'(RST_CYCLES));
`endif
        repeat (2) @(negedge clk);
        pll_locked = 1'b1;
        lat = 0;
        while (busy && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("relock_idle", 64'(busy), 64'(0));
        @(negedge clk);
        check("lockloss_no_done", 64'(done_cnt - d0), 64'(0));

        // Reset in the middle of status polling.
        obs_q.delete();
        stall_min  = 3;
        stall_max  = 3;
        zeros_left = 1000;
        @(negedge clk);
        req        = 1'b1;
        pll_locked = 1'b0;
        @(negedge clk);
        req = 1'b0;
        lat = 0;
        while (!mgmt_read && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        check("reached_rd_stat", 64'({mgmt_read, mgmt_address}), 64'({1'b1, 6'h01}));
        #2 rst_n = 1'b0;
        #1;
        check("abort_outputs", 64'({busy, done, err, mgmt_write, mgmt_read, pll_rst, mgmt_address, mgmt_writedata}), 64'(0));
        repeat (2) @(negedge clk);
        zeros_left = 0;
        pll_locked = 1'b1;
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_after_abort", 64'({busy, mgmt_write, mgmt_read, pll_rst}), 64'(0));

        run_seq("after_abort", 18'($urandom), 18'($urandom), 5'($urandom), 18'($urandom), 0, 1, 1, 1'b0);
        check("err_pulses", 64'(err_cnt), 64'(err_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
